// File: rtl/pwm_pkg.sv
// pwm_pkg: shared definitions for the PWM generator family.
//   PWM_WIDTH   - default width of the period, compare and counter datapath
//   pwm_state_t - generator state: IDLE (output parked low) or RUN
package pwm_pkg;

    localparam int PWM_WIDTH = 32;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } pwm_state_t;

endpackage

// File: rtl/pwm_generator.sv
// pwm_generator: single-channel free-running PWM with period-boundary updates.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   pwm_period   in   WIDTH  period length in clocks (0 parks the output)
//   pwm_compare  in   WIDTH  high-time in clocks (pulse high while count < compare)
//   pwm_pulse    out  registered PWM waveform
//   pwm_done     out  registered one-clock strobe on the last count of a period
//
// Period and compare are captured into shadow registers only at a period
// boundary (or every clock while idle), so a running period never glitches.
module pwm_generator
    import pwm_pkg::*;
#(
    parameter int WIDTH = PWM_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pwm_period,
    input  logic [WIDTH-1:0] pwm_compare,
    output logic             pwm_pulse,
    output logic             pwm_done
);

    pwm_state_t       st_q, st_n;
    logic [WIDTH-1:0] per_q, per_n;
    logic [WIDTH-1:0] cmp_q, cmp_n;
    logic [WIDTH-1:0] cnt_q, cnt_n;
    logic             pulse_n, done_n;
    logic             last_cnt;

    // per_q is never 0 while running, so per_q-1 cannot underflow there.
    assign last_cnt = (cnt_q == per_q - WIDTH'(1));

    always_comb begin
        st_n    = st_q;
        per_n   = per_q;
        cmp_n   = cmp_q;
        cnt_n   = cnt_q;
        pulse_n = 1'b0;
        done_n  = 1'b0;

        case (st_q)
            IDLE: begin
                per_n = pwm_period;
                cmp_n = pwm_compare;
                cnt_n = '0;
                if (pwm_period != '0) begin
                    st_n = RUN;
                end
            end
            RUN: begin
                if (last_cnt) begin
                    cnt_n = '0;
                    per_n = pwm_period;
                    cmp_n = pwm_compare;
                    if (pwm_period == '0) begin
                        st_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt_q + WIDTH'(1);
                end
            end
            default: begin
                st_n  = IDLE;
                cnt_n = '0;
            end
        endcase

        // Outputs are derived from the next-state count and shadows so the
        // registered pulse/done line up with the count they describe.
        if (st_n == RUN) begin
            pulse_n = (cnt_n < cmp_n);
            done_n  = (cnt_n == per_n - WIDTH'(1));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            st_q      <= IDLE;
            per_q     <= '0;
            cmp_q     <= '0;
            cnt_q     <= '0;
            pwm_pulse <= 1'b0;
            pwm_done  <= 1'b0;
        end else begin
            st_q      <= st_n;
            per_q     <= per_n;
            cmp_q     <= cmp_n;
            cnt_q     <= cnt_n;
            pwm_pulse <= pulse_n;
            pwm_done  <= done_n;
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// tb_pwm_generator: directed and randomized bench for pwm_generator with a
// period-level reference model (position within the current period).
module tb_pwm_generator;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] pwm_period  = '0;
    logic [31:0] pwm_compare = '0;
    logic        pwm_pulse;
    logic        pwm_done;

    int errors = 0;
    int checks = 0;

    // Reference model: a period is a record (mp, mc) plus a position k.
    bit     m_active = 1'b0;
    longint mp = 0;
    longint mc = 0;
    longint k  = 0;
    logic   exp_pulse = 1'b0;
    logic   exp_done  = 1'b0;

    pwm_generator #(.WIDTH(32)) dut (
        .clock      (clock),
        .reset      (reset),
        .pwm_period (pwm_period),
        .pwm_compare(pwm_compare),
        .pwm_pulse  (pwm_pulse),
        .pwm_done   (pwm_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Called on every rising edge, with the inputs the DUT just sampled.
    function automatic void model_edge();
        if (!reset) begin
            m_active = 1'b0;
        end else begin
            if (m_active) begin
                k++;
                if (k >= mp) m_active = 1'b0;
            end
            if (!m_active && pwm_period != 0) begin
                m_active = 1'b1;
                mp = longint'(pwm_period);
                mc = longint'(pwm_compare);
                k  = 0;
            end
        end
        exp_pulse = m_active && (k < mc);
        exp_done  = m_active && (k == mp - 1);
    endfunction

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            model_edge();
            #1;
            check("pulse", pwm_pulse, exp_pulse);
            check("done", pwm_done, exp_done);
        end
    endtask

    task automatic set_in(input logic [31:0] p, input logic [31:0] c);
        pwm_period  = p;
        pwm_compare = c;
    endtask

    // Asynchronous reset applied between edges; outputs must drop with no edge.
    task automatic async_reset_check();
        #1;
        reset = 1'b0;
        m_active = 1'b0;
        #1;
        check("rst_pulse", pwm_pulse, 1'b0);
        check("rst_done", pwm_done, 1'b0);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        // Reset state
        #2;
        check("reset_pulse", pwm_pulse, 1'b0);
        check("reset_done", pwm_done, 1'b0);
        step(2);

        // period=4, compare=2 from reset release
        set_in(32'd4, 32'd2);
        @(negedge clock);
        reset = 1'b1;
        step(12);

        // Period 4 -> 6 written mid-period
        step(2);
        set_in(32'd6, 32'd2);
        step(16);

        // Period 0 mid-period, then restore
        step(2);
        set_in(32'd0, 32'd2);
        step(10);
        set_in(32'd4, 32'd2);
        step(8);

        // Compare boundaries
        set_in(32'd4, 32'd0);
        step(8);
        set_in(32'd4, 32'd4);
        step(8);
        set_in(32'd4, 32'd7);
        step(8);

        // period = 1
        set_in(32'd1, 32'd1);
        step(6);
        set_in(32'd1, 32'd0);
        step(4);

        // Maximum period: count must run up without an early done
        set_in(32'hFFFF_FFFF, 32'd3);
        step(8);

        // Recover via reset, then reset again at count 2 of a period-4 run
        set_in(32'd4, 32'd2);
        async_reset_check();
        begin : wait_cnt2
            for (int i = 0; i < 10; i++) begin
                step(1);
                if (m_active && k == 2) disable wait_cnt2;
            end
            checks++;
            errors++;
            $error("FAIL wait_cnt2: observed=timeout expected=count 2");
        end
        async_reset_check();
        step(8);

        // Randomized inputs changed at random times
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0)
                set_in(32'($urandom_range(0, 7)), 32'($urandom_range(0, 9)));
            step(1);
        end
        set_in(32'd3, 32'd1);
        step(4);
        async_reset_check();
        step(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
